// File: rtl/cpu_core.sv
// cpu_core: four-register accumulator-style CPU driven by an internal
// FETCH/DECODE/EXEC/WB state machine on a single clock.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst        asynchronous, active-low reset
//   imem_req   fetch request, held until imem_ack
//   imem_addr  fetch address (equals pc)
//   imem_ack   instruction word valid this cycle
//   imem_data  instruction word, latched when imem_req && imem_ack
//   out_valid  OUT data valid, held until out_ready
//   out_data   value produced by OUT, stable while out_valid
//   out_ready  consumer accepts out_data
//   halted     core stopped by HALT
//   illegal    sticky flag: an undefined opcode (C/D/E) was decoded
//   dbg_pc     current program counter
//
// Instruction word: op[15:12] rd[11:10] rs[9:8] imm[7:0].
module cpu_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              halted,
    output logic              illegal,
    output logic [PC_W-1:0]   dbg_pc
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic              wr_q, wr_d;
    logic              taken_q, taken_d;
    logic              req_q, req_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   imm_pc;

    assign op      = ir_q[15:12];
    assign rd      = ir_q[11:10];
    assign rs      = ir_q[9:8];
    assign imm_ext = DATA_W'(ir_q[7:0]);
    assign imm_pc  = PC_W'(ir_q[7:0]);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        regs_d      = regs_q;
        ir_d        = ir_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        alu_d       = alu_q;
        wr_d        = wr_q;
        taken_d     = taken_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        halted_d    = halted_q;
        illegal_d   = illegal_q;

        unique case (state_q)
            S_FETCH: begin
                // req_q is low in the first cycle after reset, so a stray
                // ack there is ignored.
                if (req_q && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                opa_d = regs_q[rd];
                opb_d = regs_q[rs];
                wr_d  = (op >= 4'h1) && (op <= 4'h7);
                if (op inside {4'hC, 4'hD, 4'hE}) begin
                    illegal_d = 1'b1;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    4'h1:    alu_d = imm_ext;
                    4'h2:    alu_d = opa_q + opb_q;
                    4'h3:    alu_d = opa_q - opb_q;
                    4'h4:    alu_d = opa_q & opb_q;
                    4'h5:    alu_d = opa_q | opb_q;
                    4'h6:    alu_d = opa_q ^ opb_q;
                    4'h7:    alu_d = opb_q;
                    default: alu_d = opa_q;
                endcase
                taken_d = (op == 4'h8)
                       || ((op == 4'h9) && (opa_q == '0))
                       || ((op == 4'hA) && (opa_q != '0));
                if (op == 4'hB) begin
                    out_valid_d = 1'b1;
                    out_data_d  = opa_q;
                end
                state_d = S_WB;
            end
            S_WB: begin
                if (op == 4'hF) begin
                    // pc is left pointing at the HALT instruction.
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (!out_valid_q || out_ready) begin
                    if (wr_q) begin
                        regs_d[rd] = alu_q;
                    end
                    pc_d        = taken_q ? imm_pc : pc_q + PC_W'(1);
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_HALT: begin
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        req_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            ir_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            alu_q       <= '0;
            wr_q        <= 1'b0;
            taken_q     <= 1'b0;
            req_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            regs_q      <= regs_d;
            ir_q        <= ir_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            alu_q       <= alu_d;
            wr_q        <= wr_d;
            taken_q     <= taken_d;
            req_q       <= req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign dbg_pc    = pc_q;

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: runs small programs on an 8-bit and a 16-bit cpu_core in
// parallel, both fetching from one shared instruction memory. An ISA-level
// reference interpreter fills scoreboard queues (fetch addresses, OUT
// values) that are popped as the DUTs handshake.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req [2];
    logic        ack [2];
    logic        ov  [2];
    logic        ordy[2];
    logic        hlt [2];
    logic        ill [2];
    logic [7:0]  addr[2];
    logic [7:0]  pcd [2];
    logic [15:0] idata[2];
    logic [7:0]  od8;
    logic [15:0] od16;
    logic [31:0] odx[2];

    logic [15:0] mem [256];

    int n_chk = 0;
    int n_err = 0;
    int stall = 0;
    bit mon_en = 1'b0;

    logic [31:0] qa[$];
    logic [31:0] qo0[$];
    logic [31:0] qo1[$];
    logic [7:0]  hpc[2];
    int          ninst;
    logic        ill_exp;

    int          mcyc = 0;
    int          first_ack;
    int          halt_cyc;
    int          nloop;
    logic [31:0] last_out[2];

    initial forever #5 clk = ~clk;

    assign idata[0] = mem[addr[0]];
    assign idata[1] = mem[addr[1]];
    assign odx[0]   = 32'(od8);
    assign odx[1]   = 32'(od16);

    cpu_core #(.DATA_W(8), .PC_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .imem_req(req[0]), .imem_addr(addr[0]), .imem_ack(ack[0]), .imem_data(idata[0]),
        .out_valid(ov[0]), .out_data(od8), .out_ready(ordy[0]),
        .halted(hlt[0]), .illegal(ill[0]), .dbg_pc(pcd[0])
    );

    cpu_core #(.DATA_W(16), .PC_W(8)) dut16 (
        .clk(clk), .rst(rst),
        .imem_req(req[1]), .imem_addr(addr[1]), .imem_ack(ack[1]), .imem_data(idata[1]),
        .out_valid(ov[1]), .out_data(od16), .out_ready(ordy[1]),
        .halted(hlt[1]), .illegal(ill[1]), .dbg_pc(pcd[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] d,
                                        input logic [1:0] s, input logic [7:0] imm);
        return {op, d, s, imm};
    endfunction

    // Reference interpreter: one instruction per step, no timing.
    task automatic model(input int w);
        logic [31:0] r[4];
        logic [31:0] mask;
        logic [7:0]  pc;
        logic [7:0]  nx;
        logic [15:0] ins;
        logic [3:0]  op;
        logic [1:0]  d;
        logic [1:0]  s;
        mask = (32'd1 << w) - 32'd1;
        r = '{default: 32'd0};
        pc = 8'd0;
        for (int n = 1; n <= 4000; n++) begin
            ins = mem[pc];
            op  = ins[15:12];
            d   = ins[11:10];
            s   = ins[9:8];
            if (w == 8) qa.push_back(32'(pc));
            nx = pc + 8'd1;
            case (op)
                4'h1: r[d] = 32'(ins[7:0]) & mask;
                4'h2: r[d] = (r[d] + r[s]) & mask;
                4'h3: r[d] = (r[d] - r[s]) & mask;
                4'h4: r[d] = r[d] & r[s];
                4'h5: r[d] = r[d] | r[s];
                4'h6: r[d] = r[d] ^ r[s];
                4'h7: r[d] = r[s];
                4'h8: nx = ins[7:0];
                4'h9: if (r[d] == 32'd0) nx = ins[7:0];
                4'hA: if (r[d] != 32'd0) nx = ins[7:0];
                4'hB: if (w == 8) qo0.push_back(r[d]); else qo1.push_back(r[d]);
                4'hC, 4'hD, 4'hE: ill_exp = 1'b1;
                4'hF: begin
                    hpc[(w == 8) ? 0 : 1] = pc;
                    if (w == 8) ninst = n;
                    return;
                end
                default: ;
            endcase
            pc = nx;
        end
    endtask

    task automatic load(input int id);
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        case (id)
            1: begin // LDI/ADD/OUT
                mem[0] = enc(4'h1, 2'd0, 2'd0, 8'd5);
                mem[1] = enc(4'h1, 2'd1, 2'd0, 8'd7);
                mem[2] = enc(4'h2, 2'd0, 2'd1, 8'd0);
                mem[3] = enc(4'hB, 2'd0, 2'd0, 8'd0);
                mem[4] = enc(4'hF, 2'd0, 2'd0, 8'd0);
            end
            2: begin // SUB wrap
                mem[0] = enc(4'h1, 2'd0, 2'd0, 8'd0);
                mem[1] = enc(4'h1, 2'd1, 2'd0, 8'd1);
                mem[2] = enc(4'h3, 2'd0, 2'd1, 8'd0);
                mem[3] = enc(4'hB, 2'd0, 2'd0, 8'd0);
                mem[4] = enc(4'hF, 2'd0, 2'd0, 8'd0);
            end
            3: begin // pc wrap 0xFF -> 0x00
                mem[8'h00] = enc(4'h9, 2'd0, 2'd0, 8'hFE);
                mem[8'h01] = enc(4'hB, 2'd0, 2'd0, 8'd0);
                mem[8'h02] = enc(4'hF, 2'd0, 2'd0, 8'd0);
                mem[8'hFE] = enc(4'h1, 2'd0, 2'd0, 8'd1);
            end
            4: begin // JNZ loop, JZ to 0x20
                mem[0]     = enc(4'h1, 2'd2, 2'd0, 8'd3);
                mem[1]     = enc(4'h1, 2'd1, 2'd0, 8'd1);
                mem[2]     = enc(4'h3, 2'd2, 2'd1, 8'd0);
                mem[3]     = enc(4'hA, 2'd2, 2'd0, 8'd2);
                mem[4]     = enc(4'hB, 2'd2, 2'd0, 8'd0);
                mem[5]     = enc(4'h9, 2'd3, 2'd0, 8'h20);
                mem[8'h20] = enc(4'hF, 2'd0, 2'd0, 8'd0);
            end
            5: begin // illegal opcodes
                mem[0] = enc(4'h1, 2'd0, 2'd0, 8'd9);
                mem[1] = 16'hC000;
                mem[2] = enc(4'hB, 2'd0, 2'd0, 8'd0);
                mem[3] = 16'hD5FF;
                mem[4] = enc(4'hB, 2'd0, 2'd0, 8'd0);
                mem[5] = enc(4'hB, 2'd1, 2'd0, 8'd0);
                mem[6] = enc(4'hF, 2'd0, 2'd0, 8'd0);
            end
            6: begin // width regression
                mem[0] = enc(4'h1, 2'd0, 2'd0, 8'hFF);
                mem[1] = enc(4'h2, 2'd0, 2'd0, 8'd0);
                mem[2] = enc(4'hB, 2'd0, 2'd0, 8'd0);
                mem[3] = enc(4'hF, 2'd0, 2'd0, 8'd0);
            end
            default: begin // logic ops, MOV, JMP
                mem[0]     = enc(4'h1, 2'd0, 2'd0, 8'h3C);
                mem[1]     = enc(4'h1, 2'd1, 2'd0, 8'h0F);
                mem[2]     = enc(4'h7, 2'd2, 2'd0, 8'd0);
                mem[3]     = enc(4'h4, 2'd2, 2'd1, 8'd0);
                mem[4]     = enc(4'hB, 2'd2, 2'd0, 8'd0);
                mem[5]     = enc(4'h7, 2'd3, 2'd0, 8'd0);
                mem[6]     = enc(4'h5, 2'd3, 2'd1, 8'd0);
                mem[7]     = enc(4'hB, 2'd3, 2'd0, 8'd0);
                mem[8]     = enc(4'h6, 2'd0, 2'd1, 8'd0);
                mem[9]     = enc(4'hB, 2'd0, 2'd0, 8'd0);
                mem[10]    = enc(4'h8, 2'd0, 2'd0, 8'h10);
                mem[8'h10] = enc(4'hF, 2'd0, 2'd0, 8'd0);
            end
        endcase
    endtask

    // Input drivers at negedge, monitor/scoreboard at negedge+2.
    initial begin
        int          wcnt[2];
        int          rcnt[2];
        logic        p_req[2], p_ack[2], p_ov[2], p_or[2];
        logic [7:0]  p_addr[2];
        logic [31:0] p_od[2];
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            ack[i] = 1'b0; ordy[i] = 1'b1; wcnt[i] = 0; rcnt[i] = 0;
            p_req[i] = 1'b0; p_ack[i] = 1'b0; p_ov[i] = 1'b0; p_or[i] = 1'b0;
            p_addr[i] = 8'd0; p_od[i] = 32'd0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!req[i]) begin
                    ack[i]  = 1'b0;
                    wcnt[i] = (stall == 0) ? 0 : (stall == 1) ? int'($urandom_range(0, 5)) : 3;
                end else if (wcnt[i] == 0) begin
                    ack[i] = 1'b1;
                end else begin
                    wcnt[i]--;
                end
                if (!ov[i]) begin
                    ordy[i] = (stall == 0);
                    rcnt[i] = 0;
                end else if (stall != 0 && rcnt[i] < 6) begin
                    ordy[i] = 1'b0;
                    rcnt[i]++;
                end else begin
                    ordy[i] = 1'b1;
                end
            end
            #2;
            mcyc++;
            for (int i = 0; i < 2; i++) begin
                if (mon_en) begin
                    if (p_req[i] && !p_ack[i]) begin
                        check("req_hold", 32'(req[i]), 32'd1);
                        check("addr_hold", 32'(addr[i]), 32'(p_addr[i]));
                    end
                    if (p_ov[i] && !p_or[i]) begin
                        check("ov_hold", 32'(ov[i]), 32'd1);
                        check("od_hold", odx[i], p_od[i]);
                    end
                    if (p_ov[i] && p_or[i]) check("ov_drop", 32'(ov[i]), 32'd0);
                    if (i == 0 && req[0] && ack[0]) begin
                        if (qa.size() == 0) check("fetch_extra", 32'(qa.size()), 32'd1);
                        else begin
                            e = qa.pop_front();
                            check("fetch_addr", 32'(addr[0]), e);
                        end
                        if (addr[0] == 8'd2) nloop++;
                        if (first_ack < 0) first_ack = mcyc;
                    end
                    if (ov[i] && ordy[i]) begin
                        if (i == 0) begin
                            if (qo0.size() == 0) check("out8_extra", 32'(qo0.size()), 32'd1);
                            else begin e = qo0.pop_front(); check("out8_data", odx[0], e); end
                        end else begin
                            if (qo1.size() == 0) check("out16_extra", 32'(qo1.size()), 32'd1);
                            else begin e = qo1.pop_front(); check("out16_data", odx[1], e); end
                        end
                        last_out[i] = odx[i];
                    end
                    if (i == 0 && hlt[0] && halt_cyc < 0) halt_cyc = mcyc;
                end
                p_req[i] = req[i]; p_ack[i] = ack[i]; p_ov[i] = ov[i]; p_or[i] = ordy[i];
                p_addr[i] = addr[i]; p_od[i] = odx[i];
            end
        end
    end

    task automatic reset_checks(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_req"}, 32'(req[i]), 32'd0);
            check({tag, "_ov"}, 32'(ov[i]), 32'd0);
            check({tag, "_od"}, odx[i], 32'd0);
            check({tag, "_hlt"}, 32'(hlt[i]), 32'd0);
            check({tag, "_ill"}, 32'(ill[i]), 32'd0);
            check({tag, "_pc"}, 32'(pcd[i]), 32'd0);
        end
    endtask

    task automatic run_prog(input int id, input int stl);
        int cyc;
        @(negedge clk); #4;
        mon_en = 1'b0;
        rst = 1'b0;
        stall = stl;
        qa.delete(); qo0.delete(); qo1.delete();
        ill_exp = 1'b0;
        load(id);
        model(8);
        model(16);
        first_ack = -1; halt_cyc = -1; nloop = 0;
        last_out[0] = 32'hDEAD; last_out[1] = 32'hDEAD;
        repeat (2) @(negedge clk);
        #3;
        reset_checks("rst");
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        cyc = 0;
        while (!(hlt[0] && hlt[1]) && cyc < 3000) begin
            @(negedge clk); #3;
            cyc++;
        end
        check("halt_reached", 32'(hlt[0] && hlt[1]), 32'd1);
        @(negedge clk); #3;
        mon_en = 1'b0;
        check("fetch_left", 32'(qa.size()), 32'd0);
        check("out8_left", 32'(qo0.size()), 32'd0);
        check("out16_left", 32'(qo1.size()), 32'd0);
        for (int i = 0; i < 2; i++) begin
            check("halt_pc", 32'(pcd[i]), 32'(hpc[i]));
            check("halt_req", 32'(req[i]), 32'd0);
            check("illegal", 32'(ill[i]), 32'(ill_exp));
        end
        if (stl == 0) check("cycles", 32'(halt_cyc - first_ack), 32'(4 * ninst));
    endtask

    task automatic abort_test(input bit mid_out);
        int cyc;
        @(negedge clk); #4;
        mon_en = 1'b0;
        rst = 1'b0;
        stall = 2;
        load(1);
        repeat (2) @(negedge clk);
        #4;
        rst = 1'b1;
        cyc = 0;
        while (!(mid_out ? ov[0] : (req[0] && !ack[0] && pcd[0] != 8'd0)) && cyc < 500) begin
            @(negedge clk); #3;
            cyc++;
        end
        check(mid_out ? "abort_wait_out" : "abort_wait_fetch", 32'(cyc < 500), 32'd1);
        rst = 1'b0;
        #1;
        reset_checks(mid_out ? "abort_out" : "abort_fetch");
        repeat (2) @(negedge clk);
        #4;
        rst = 1'b1;
        cyc = 0;
        while (!req[0] && cyc < 10) begin
            @(negedge clk); #3;
            cyc++;
        end
        check("restart_req", 32'(req[0]), 32'd1);
        check("restart_addr", 32'(addr[0]), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        run_prog(1, 0);
        check("p1_out", last_out[0], 32'd12);
        check("p1_halt_pc", 32'(pcd[0]), 32'd4);
        run_prog(1, 1);
        check("p1_out_stall", last_out[0], 32'd12);
        run_prog(2, 0);
        check("p2_wrap8", last_out[0], 32'hFF);
        check("p2_wrap16", last_out[1], 32'hFFFF);
        run_prog(2, 1);
        check("p2_wrap8_stall", last_out[0], 32'hFF);
        run_prog(3, 0);
        check("p3_pcwrap_out", last_out[0], 32'd1);
        check("p3_halt_pc", 32'(pcd[0]), 32'd2);
        run_prog(4, 0);
        check("p4_loops", 32'(nloop), 32'd3);
        check("p4_out", last_out[0], 32'd0);
        check("p4_jz_pc", 32'(pcd[0]), 32'h20);
        run_prog(4, 1);
        check("p4_loops_stall", 32'(nloop), 32'd3);
        run_prog(5, 0);
        check("p5_ill", 32'(ill[0]), 32'd1);
        check("p5_out", last_out[0], 32'd0);
        run_prog(5, 1);
        run_prog(6, 0);
        check("p6_out16", last_out[1], 32'h1FE);
        check("p6_out8", last_out[0], 32'hFE);
        run_prog(7, 0);
        check("p7_xor", last_out[0], 32'h33);
        run_prog(7, 1);
        abort_test(1'b1);
        abort_test(1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Parametrised successor to the 4-register fixed-phase CPU.
- Replaces the external phase-clock generator with an internal FETCH/DECODE/EXEC/WB state machine on a single clock.
- Generalises data and PC width, fetches from an instruction memory through a req/ack handshake, and adds branches, a halt, an illegal-opcode flag and a back-pressured output port.
- Sits between the instruction ROM model and the top-level testbench.

Parameters:
DATA_W, 8, register/ALU width in bits (legal 8..32)
PC_W, 8, program counter / imem address width (legal 8..16)

Ports:
clk  in  1  system clock; all state on posedge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request, held until ack
imem_addr  out  PC_W  fetch address (= pc while imem_req)
imem_ack  in  1  instruction valid this cycle
imem_data  in  16  instruction word, sampled when imem_req&&imem_ack
out_valid  out  1  OUT data valid
out_data  out  DATA_W  value from OUT instruction
out_ready  in  1  consumer accepts out_data
halted  out  1  core stopped by HALT
illegal  out  1  sticky: undefined opcode seen
dbg_pc  out  PC_W  current pc

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset (rst=0) state: all 4 regs=0, pc=0, state=FETCH, imem_req=0, out_valid=0, out_data=0, halted=0, illegal=0. Reset mid-instruction or mid-handshake aborts immediately; no partial writeback.
- Instruction format: op[15:12], rd[11:10], rs[9:8], imm[7:0]. 4 registers, fixed.
- Opcodes:
  - 0 NOP
  - 1 LDI rd=zext(imm)
  - 2 ADD rd=rd+rs
  - 3 SUB rd=rd-rs
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 MOV rd=rs
  - 8 JMP pc=zext(imm)
  - 9 JZ (taken if rd==0)
  - A JNZ (taken if rd!=0)
  - B OUT
  - F HALT
  - C,D,E: illegal; execute as NOP and set illegal (sticky until reset).
- Arithmetic: modulo 2^DATA_W; no flags; SUB wraps (0-1 = all ones).
- PC: increments modulo 2^PC_W, so 2^PC_W-1 wraps to 0. Branch targets are zext(imm) to PC_W.
- FSM:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_data and go to DECODE. imem_req drops the cycle after ack. Ack in the first req cycle is legal, giving a minimum fetch of 1 cycle.
  - DECODE: read rd/rs operands, classify opcode; 1 cycle.
  - EXEC: compute ALU result / branch decision; 1 cycle.
  - WB:
    - Write rd for ALU/LDI/MOV.
    - Set pc to target if a branch is taken, else pc+1.
    - For OUT: out_data=rd, out_valid=1, stay in WB until out_valid&&out_ready; pc updates in the accept cycle; out_valid drops the next cycle.
    - Then go to FETCH.
  - HALT: entered from WB when op=F; halted=1; imem_req=0; pc stays at the HALT address; no exit except reset.
- Latency: minimum 4 cycles per instruction (ack same cycle, out_ready high). Register writes are visible to the next instruction's DECODE.
- out_data holds its value while out_valid=1 regardless of out_ready.
- dbg_pc always equals pc.

Test Plan:
- Reset/LDI/ADD: program LDI r0,5; LDI r1,7; ADD r0,r1; OUT r0; HALT with ack tied 1 and out_ready tied 1 -> one out_valid pulse with out_data=12; halted=1 at pc=4; 4 cycles per instruction.
- Wrap: DATA_W=8, LDI r0,0; LDI r1,1; SUB r0,r1; OUT r0 -> out_data=255. Separately, with pc run to 255 via NOPs -> next fetch addr=0.
- Branching: LDI r2,3; JNZ r2→loop doing SUB r2,r1 with r1=1; OUT r2 after exit -> exactly 3 loop iterations and out_data=0. JZ with r3=0 to imm 0x20 -> imem_addr=0x20.
- Handshakes: random imem_ack delay of 0-5 cycles and out_ready low for 6 cycles on an OUT -> imem_req/imem_addr and out_valid/out_data stable while waiting; results identical to the zero-stall run.
- Illegal opcode: instruction 0xC000 -> illegal=1 and stays 1, regs unchanged, execution continues at pc+1.
- Async reset: assert rst=0 mid-OUT stall (out_valid=1) and mid-fetch -> all outputs at reset values immediately without a clock edge; after release, first imem_addr=0. DATA_W=16 regression: LDI 0xFF; ADD to itself -> out_data=0x01FE.
